// File: rtl/bus_reader.sv
`default_nettype none
// ============================================================================
// bus_reader : round-robin tri-state bus arbiter with capture FIFO   (rev 1.0)
// ============================================================================
module bus_reader #(
    parameter int WIDTH = 4,
    parameter int NSRC  = 4,
    parameter int DEPTH = 4,
    localparam int SW   = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NSRC-1:0]  req,
    output logic [NSRC-1:0]  en,
    output logic [NSRC-1:0]  ack,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DRIVE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_TURN    = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [SW-1:0]   last_q, last_d;
    logic [NSRC-1:0] en_q, en_d;
    logic [NSRC-1:0] ack_q, ack_d;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [SW-1:0]    src_q  [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q;

    logic            grant_found;
    logic [SW-1:0]   grant_idx;
    logic [SW-1:0]   cand;
    logic            push, pop;

    // Cyclic search starting one past the last winner gives strict round-robin.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NSRC; k++) begin
            cand = SW'((int'(last_q) + k) % NSRC);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        en_d    = en_q;
        ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                en_d = '0;
                // A free slot is reserved up front, so the capture can never overflow.
                if (grant_found && (count_q < CW'(DEPTH))) begin
                    state_d = S_DRIVE;
                    sel_d   = grant_idx;
                    last_d  = grant_idx;
                    en_d    = NSRC'(1) << grant_idx;
                end
            end
            S_DRIVE: begin
                state_d = S_CAPTURE;
                ack_d   = NSRC'(1) << sel_q;
            end
            S_CAPTURE: begin
                state_d = S_TURN;
                en_d    = '0;
            end
            S_TURN: begin
                state_d = S_IDLE;
                en_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
                en_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            last_q  <= SW'(NSRC - 1);
            en_q    <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
        end
    end

    assign push = (state_q == S_CAPTURE);
    assign pop  = (count_q != '0) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                src_q[i]  <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                data_q[wr_q] <= bus_in;
                src_q[wr_q]  <= sel_q;
                wr_q         <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Gating with rst_n lets the bus float the instant reset asserts.
    assign en        = en_q & {NSRC{rst_n}};
    assign ack       = ack_q;
    assign out_data  = data_q[rd_q];
    assign out_src   = src_q[rd_q];
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_reader.sv
`default_nettype none
// ============================================================================
// tb_bus_reader : directed scoreboard bench for bus_reader            (rev 1.0)
// ============================================================================
module tb_bus_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] en;
    logic [3:0] ack;
    logic [3:0] bus_in;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       busy;

    logic [3:0] drv_val [4];

    typedef struct packed {
        logic [1:0] src;
        logic [3:0] data;
    } exp_t;

    exp_t scb[$];
    int   n_vec = 0;
    int   n_err = 0;

    bus_reader #(.WIDTH(4), .NSRC(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .en        (en),
        .ack       (ack),
        .bus_in    (bus_in),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Resolved bus: the enabled driver's value, pulled high when floating.
    always_comb begin
        bus_in = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) bus_in = drv_val[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("en_safety", {31'd0, ($countones(en) > 1) || (!busy && en != 4'd0)}, 32'd0);
        if (rst_n && out_valid && out_ready) begin
            if (scb.size() == 0) begin
                chk("unexpected_output", {26'd0, out_src, out_data}, 32'hFFFF);
            end else begin
                exp_t e;
                e = scb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_src", out_src, e.src);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (ack == 4'd0 && n < 20);
        if (ack == 4'd0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_count(input logic [2:0] v);
        int n;
        n = 0;
        while (count != v && n < 60) begin
            cyc();
            n++;
        end
        chk("wait_count", count, v);
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while ((busy || count != 3'd0 || scb.size() != 0) && n < 60) begin
            cyc();
            n++;
        end
        chk("drain", {31'd0, busy || count != 3'd0}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        scb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req = 4'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drv_val[i] = 4'h0;
        cyc();
        chk("rst_en", en, 4'd0);
        chk("rst_ack", ack, 4'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 4'd0);
        chk("rst_src", out_src, 2'd0);
        chk("rst_count", count, 3'd0);
        chk("rst_busy", busy, 1'b0);
        cyc();
        rst_n = 1'b1;

        // Single transfer from driver 0
        drv_val[0] = 4'hA;
        out_ready = 1'b1;
        req = 4'b0001;
        scb.push_back('{src: 2'd0, data: 4'hA});
        cyc();
        chk("t1_drive_en", en, 4'b0001);
        chk("t1_drive_ack", ack, 4'b0000);
        chk("t1_busy", busy, 1'b1);
        req = 4'b0000;
        cyc();
        chk("t1_cap_en", en, 4'b0001);
        chk("t1_cap_ack", ack, 4'b0001);
        cyc();
        chk("t1_turn_en", en, 4'b0000);
        chk("t1_turn_valid", out_valid, 1'b1);
        chk("t1_turn_count", count, 3'd1);
        chk("t1_turn_data", out_data, 4'hA);
        wait_drained();

        // Round robin with all drivers requesting
        do_reset();
        drv_val[0] = 4'h3; drv_val[1] = 4'h5; drv_val[2] = 4'h7; drv_val[3] = 4'h9;
        scb.push_back('{src: 2'd0, data: 4'h3});
        scb.push_back('{src: 2'd1, data: 4'h5});
        scb.push_back('{src: 2'd2, data: 4'h7});
        scb.push_back('{src: 2'd3, data: 4'h9});
        scb.push_back('{src: 2'd0, data: 4'h3});
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            do begin
                cyc();
                n++;
            end while (ack == 4'd0 && n < 20);
            chk("rr_ack", ack, 4'd1 << (i % 4));
            if (i > 0) chk("rr_spacing", n, 4);
            if (i == 4) req = 4'b0000;
        end
        wait_drained();

        // Fill FIFO with downstream stalled
        out_ready = 1'b0;
        drv_val[1] = 4'hC;
        for (int i = 0; i < 4; i++) scb.push_back('{src: 2'd1, data: 4'hC});
        req = 4'b0010;
        wait_count(3'd4);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("full_en", en, 4'd0);
            chk("full_busy", busy, 1'b0);
            chk("full_count", count, 3'd4);
        end
        drv_val[1] = 4'hD;
        scb.push_back('{src: 2'd1, data: 4'hD});
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("pop1_count", count, 3'd3);
        chk("pop1_en", en, 4'd0);
        cyc();
        chk("regrant_en", en, 4'b0010);
        req = 4'b0000;
        cyc();
        chk("regrant_ack", ack, 4'b0010);
        out_ready = 1'b1;
        cyc();
        chk("pushpop_count", count, 3'd3);
        wait_drained();

        // Driver 2 drops its request mid-transfer
        drv_val[2] = 4'h6;
        scb.push_back('{src: 2'd2, data: 4'h6});
        req = 4'b0110;
        cyc();
        chk("drop_en", en, 4'b0100);
        req = 4'b0010;
        cyc();
        chk("drop_ack", ack, 4'b0100);
        cyc();
        cyc();
        scb.push_back('{src: 2'd1, data: 4'hD});
        cyc();
        chk("skip_en", en, 4'b0010);
        req = 4'b0000;
        repeat (3) cyc();
        wait_drained();

        // Reset in the middle of a capture
        req = 4'b1010;
        wait_ack();
        chk("pre_rst_ack", ack, 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en", en, 4'd0);
        chk("arst_ack", ack, 4'd0);
        chk("arst_count", count, 3'd0);
        chk("arst_valid", out_valid, 1'b0);
        scb.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
        scb.push_back('{src: 2'd1, data: 4'hD});
        wait_ack();
        chk("post_rst_ack", ack, 4'b0010);
        req = 4'b0000;
        wait_drained();
        chk("scb_empty", scb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
